// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection and single-outstanding imem fetch with one-instruction buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_f_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] pred_pc_target_i,
  input  logic        pc_src_pred_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic [31:0] pred_pc_target_f_o,
  output logic        pc_src_pred_f_o,
  output logic        valid_f_o
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic drop_q, drop_d, kill;
  assign kill = drop_q | redirect_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0013;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      drop_q  <= drop_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    drop_d  = drop_q;
    case (state_q)
      S_REQ: begin
        state_d = imem_gnt_i ? S_WAIT : S_REQ;
        drop_d  = imem_gnt_i ? redirect_i : drop_q;
      end
      S_WAIT: begin
        state_d = imem_rvalid_i ? (kill ? S_REQ : S_HOLD) : S_WAIT;
        instr_d = (imem_rvalid_i && !kill) ? imem_rdata_i : instr_q;
        drop_d  = imem_rvalid_i ? 1'b0 : kill;
      end
      S_HOLD: begin
        state_d = (redirect_i || !stall_f_i) ? S_REQ : S_HOLD;
        pc_d    = stall_f_i ? pc_q : (pc_src_pred_i ? (pred_pc_target_i & ~32'd3) : pc_q + 32'd4);
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_i) pc_d = redirect_pc_i & ~32'd3;
  end
  assign imem_req_o         = (state_q == S_REQ);
  assign imem_addr_o        = pc_q;
  assign valid_f_o          = (state_q == S_HOLD);
  assign instr_f_o          = instr_q;
  assign pc_f_o             = pc_q;
  assign pc_plus4_f_o       = pc_q + 32'd4;
  assign pred_pc_target_f_o = pred_pc_target_i;
  assign pc_src_pred_f_o    = pc_src_pred_i;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven and scoreboarded checks of fetch_stage against a latency-programmable memory model
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i = 1'b1, stall_f_i = 1'b0, redirect_i = 1'b0, pc_src_pred_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, pred_pc_target_i = '0, imem_rdata_i = '0;
  logic imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic imem_req_o, pc_src_pred_f_o, valid_f_o;
  logic [31:0] imem_addr_o, instr_f_o, pc_f_o, pc_plus4_f_o, pred_pc_target_f_o;
  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .reset_i(reset_i), .stall_f_i(stall_f_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .pred_pc_target_i(pred_pc_target_i), .pc_src_pred_i(pc_src_pred_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_f_o(instr_f_o),
    .pc_f_o(pc_f_o), .pc_plus4_f_o(pc_plus4_f_o), .pred_pc_target_f_o(pred_pc_target_f_o),
    .pc_src_pred_f_o(pc_src_pred_f_o), .valid_f_o(valid_f_o)
  );
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct {logic pred; logic [31:0] tgt; logic [31:0] nxt;} vec_t;
  exp_t sb[$];
  int passed = 0, total = 0, lat = 1, pend_cnt = 0, n;
  logic [31:0] pend_addr = '0;
  always @(negedge clk)
    assert (reset_i || !imem_rvalid_i || (!imem_req_o && !valid_f_o))
      else $error("FAIL rvalid_protocol: rvalid=1 outside wait state");
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic cycle();
    logic acc, r;
    logic [31:0] a;
    acc = imem_req_o & imem_gnt_i;
    a = imem_addr_o;
    r = reset_i;
    @(posedge clk);
    #1;
    if (r) pend_cnt = 0;
    else if (acc) begin
      pend_cnt = lat;
      pend_addr = a;
    end else if (pend_cnt > 0) pend_cnt--;
    imem_rvalid_i = (pend_cnt == 1);
    imem_rdata_i = imem_rvalid_i ? mem(pend_addr) : 32'h0;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!valid_f_o && cnt < 20) begin
      cycle();
      cnt++;
    end
    check("wait_valid", {31'b0, valid_f_o}, 32'd1);
  endtask
  task automatic take();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("pc_f", pc_f_o, e.pc);
    check("instr_f", instr_f_o, e.instr);
    check("pc_plus4", pc_plus4_f_o, e.pc + 32'd4);
  endtask
  task automatic consume(input logic pred, input logic [31:0] tgt, input logic [31:0] nxt);
    pc_src_pred_i = pred;
    pred_pc_target_i = tgt;
    #1;
    check("pred_tgt_pass", pred_pc_target_f_o, tgt);
    check("pred_src_pass", {31'b0, pc_src_pred_f_o}, {31'b0, pred});
    cycle();
    pc_src_pred_i = 1'b0;
    pred_pc_target_i = '0;
    check("req_after_consume", {31'b0, imem_req_o}, 32'd1);
    check("addr_after_consume", imem_addr_o, nxt);
  endtask
  task automatic redirect_req(input logic [31:0] rpc);
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = rpc;
    cycle();
    redirect_i = 1'b0;
  endtask
  vec_t vec[7];
  initial begin
    vec = '{'{1'b0, 32'h0, 32'h4}, '{1'b0, 32'h0, 32'h8}, '{1'b0, 32'h0, 32'hC},
            '{1'b0, 32'h0, 32'h10}, '{1'b1, 32'h40, 32'h40}, '{1'b1, 32'h7F, 32'h7C},
            '{1'b0, 32'h0, 32'h80}};
    cycle();
    cycle();
    reset_i = 1'b0;
    check("rst_pc", pc_f_o, 32'h0);
    check("rst_valid", {31'b0, valid_f_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd1);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_instr", instr_f_o, 32'h0000_0013);
    imem_gnt_i = 1'b1;
    sb.push_back('{32'h0, mem(32'h0)});
    foreach (vec[i]) begin
      wait_valid(n);
      check("latency", n, 2);
      take();
      consume(vec[i].pred, vec[i].tgt, vec[i].nxt);
      sb.push_back('{vec[i].nxt, mem(vec[i].nxt)});
    end
    wait_valid(n);
    take();
    stall_f_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_hold", {valid_f_o, imem_req_o, pc_f_o[29:0]}, {1'b1, 1'b0, 30'h80});
      check("stall_instr", instr_f_o, mem(32'h80));
    end
    stall_f_i = 1'b0;
    cycle();
    check("release_addr", {imem_req_o, imem_addr_o[30:0]}, {1'b1, 31'h84});
    redirect_req(32'h20);
    check("redirect_in_req", {imem_req_o, imem_addr_o[30:0]}, {1'b1, 31'h20});
    imem_gnt_i = 1'b1;
    lat = 2;
    cycle();
    check("wait_req_low", {31'b0, imem_req_o}, 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    cycle();
    redirect_i = 1'b0;
    check("wait_redir_pc", pc_f_o, 32'h100);
    check("wait_redir_state", {30'b0, valid_f_o, imem_req_o}, 32'd0);
    cycle();
    check("drop_valid", {31'b0, valid_f_o}, 32'd0);
    check("drop_refetch", {imem_req_o, imem_addr_o[30:0]}, {1'b1, 31'h100});
    lat = 1;
    sb.push_back('{32'h100, mem(32'h100)});
    wait_valid(n);
    take();
    consume(1'b0, 32'h0, 32'h104);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    cycle();
    redirect_i = 1'b0;
    check("gnt_redir_pc", pc_f_o, 32'h200);
    cycle();
    check("gnt_redir_drop", {valid_f_o, imem_req_o, imem_addr_o[29:0]}, {1'b0, 1'b1, 30'h200});
    cycle();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    cycle();
    redirect_i = 1'b0;
    check("rvalid_redir_drop", {valid_f_o, imem_req_o, imem_addr_o[29:0]}, {1'b0, 1'b1, 30'h300});
    sb.push_back('{32'h300, mem(32'h300)});
    wait_valid(n);
    take();
    stall_f_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h400;
    cycle();
    stall_f_i = 1'b0;
    redirect_i = 1'b0;
    check("hold_redir", {valid_f_o, imem_req_o, imem_addr_o[29:0]}, {1'b0, 1'b1, 30'h400});
    redirect_req(32'h80);
    imem_gnt_i = 1'b1;
    lat = 2;
    cycle();
    check("pre_rst_wait", {imem_req_o, pc_f_o[30:0]}, {1'b0, 31'h80});
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    check("midrst_pc", pc_f_o, 32'h0);
    check("midrst_state", {30'b0, valid_f_o, imem_req_o}, 32'd1);
    check("midrst_addr", imem_addr_o, 32'h0);
    check("midrst_instr", instr_f_o, 32'h0000_0013);
    lat = 1;
    redirect_req(32'hFFFF_FFFF);
    check("wrap_pc", pc_f_o, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4_f_o, 32'h0);
    imem_gnt_i = 1'b1;
    sb.push_back('{32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    wait_valid(n);
    take();
    consume(1'b0, 32'h0, 32'h0);
    sb.push_back('{32'h0, mem(32'h0)});
    wait_valid(n);
    take();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
